// File: rtl/dma_page_reader.sv
// Reads ring pages back via DMA: one 64 B control record, then the page. Every payload beat is checked against an incrementing pattern.
// Commands are held until ready; data ready is only high in the data states; one page is credited to gpu_read_count per ADVANCE cycle.
module dma_page_reader #(
  parameter int PAGE_SIZE = 2*1024*1024,
  parameter int CTRL_NUM  = 1024,
  parameter int TIMER_W   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               axis_dma_read_cmd_valid,
  input  logic               axis_dma_read_cmd_ready,
  output logic [63:0]        axis_dma_read_cmd_address,
  output logic [31:0]        axis_dma_read_cmd_length,
  input  logic [511:0]       axis_dma_read_data_data,
  input  logic [63:0]        axis_dma_read_data_keep,
  input  logic               axis_dma_read_data_last,
  input  logic               axis_dma_read_data_valid,
  output logic               axis_dma_read_data_ready,
  input  logic [63:0]        transfer_base_addr,
  input  logic [31:0]        transfer_start_page,
  input  logic [31:0]        transfer_length,
  input  logic [31:0]        transfer_offset,
  input  logic [31:0]        work_page_size,
  input  logic               transfer_start,
  input  logic [31:0]        gpu_write_count,
  output logic [31:0]        gpu_read_count,
  output logic [31:0]        error_cnt,
  output logic [31:0]        error_index,
  output logic               len_error,
  output logic               busy,
  output logic [TIMER_W-1:0] rd_th_sum
);
  localparam int          PAGE_SHIFT = $clog2(PAGE_SIZE);
  localparam logic [31:0] PAGE_BYTES = 32'(PAGE_SIZE);
  localparam logic [63:0] PAGE_STEP  = 64'(PAGE_SIZE);
  localparam logic [31:0] CTRL_LAST  = 32'(CTRL_NUM - 1);

  typedef enum logic [3:0] {
    IDLE, START, WAIT_AVAIL, CTRL_CMD, CTRL_DATA, PAGE_CMD, PAGE_DATA, ADVANCE, DONE
  } state_t;

  state_t             state_q, state_d;
  logic               start_r_q, start_rr_q;
  logic [63:0]        start_addr_q, start_addr_d, page_addr_q, page_addr_d, ctrl_addr_q, ctrl_addr_d;
  logic [31:0]        remain_q, remain_d, page_idx_q, page_idx_d, ctrl_idx_q, ctrl_idx_d;
  logic [31:0]        rec_len_q, rec_len_d, beat_cnt_q, beat_cnt_d;
  logic [31:0]        gpu_read_count_q, gpu_read_count_d, error_cnt_q, error_cnt_d;
  logic [31:0]        error_index_q, error_index_d;
  logic               len_error_q, len_error_d, th_run_q, th_run_d;
  logic [TIMER_W-1:0] rd_th_sum_q, rd_th_sum_d;

  logic        start_edge;
  logic [63:0] start_calc;
  logic [31:0] rec_in, last_idx, remain_new;
  logic        unused_ok;

  assign start_edge = start_r_q & ~start_rr_q;
  assign start_calc = transfer_base_addr + ({32'd0, transfer_start_page} << PAGE_SHIFT);
  assign rec_in     = axis_dma_read_data_data[31:0];
  assign last_idx   = (rec_len_q >> 6) - 32'd1;
  assign unused_ok  = ^{axis_dma_read_data_keep, axis_dma_read_data_data[510:32]};

  always_comb begin
    state_d          = state_q;
    start_addr_d     = start_addr_q;
    page_addr_d      = page_addr_q;
    ctrl_addr_d      = ctrl_addr_q;
    remain_d         = remain_q;
    page_idx_d       = page_idx_q;
    ctrl_idx_d       = ctrl_idx_q;
    rec_len_d        = rec_len_q;
    beat_cnt_d       = beat_cnt_q;
    gpu_read_count_d = gpu_read_count_q;
    error_cnt_d      = error_cnt_q;
    error_index_d    = error_index_q;
    len_error_d      = len_error_q;
    th_run_d         = th_run_q;
    rd_th_sum_d      = rd_th_sum_q;
    remain_new       = '0;
    axis_dma_read_cmd_valid   = 1'b0;
    axis_dma_read_cmd_address = ctrl_addr_q;
    axis_dma_read_cmd_length  = 32'h40;
    axis_dma_read_data_ready  = 1'b0;

    // Throughput timer runs from the cycle after the first accepted command until DONE.
    if (th_run_q && state_q != DONE) rd_th_sum_d = rd_th_sum_q + 1'b1;
    if (axis_dma_read_cmd_valid && axis_dma_read_cmd_ready) th_run_d = 1'b1;

    case (state_q)
      IDLE: if (start_edge) begin
        state_d       = START;
        start_addr_d  = start_calc;
        page_addr_d   = start_calc;
        ctrl_addr_d   = transfer_base_addr;
        remain_d      = transfer_length;
        page_idx_d    = '0;
        ctrl_idx_d    = '0;
        error_cnt_d   = '0;
        error_index_d = '0;
        len_error_d   = 1'b0;
        rd_th_sum_d   = '0;
      end
      START: state_d = (remain_q == '0) ? DONE : WAIT_AVAIL;
      WAIT_AVAIL: if (gpu_write_count - gpu_read_count_q != '0) state_d = CTRL_CMD;
      CTRL_CMD: begin
        axis_dma_read_cmd_valid = 1'b1;
        if (axis_dma_read_cmd_ready) begin
          state_d  = CTRL_DATA;
          th_run_d = 1'b1;
        end
      end
      CTRL_DATA: begin
        axis_dma_read_data_ready = 1'b1;
        if (axis_dma_read_data_valid) begin
          rec_len_d = rec_in;
          if (!axis_dma_read_data_data[511] || rec_in == '0 || rec_in[5:0] != '0 ||
              rec_in > PAGE_BYTES || !axis_dma_read_data_last) begin
            len_error_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = PAGE_CMD;
          end
        end
      end
      PAGE_CMD: begin
        axis_dma_read_cmd_valid   = 1'b1;
        axis_dma_read_cmd_address = page_addr_q;
        axis_dma_read_cmd_length  = rec_len_q;
        if (axis_dma_read_cmd_ready) begin
          state_d    = PAGE_DATA;
          beat_cnt_d = '0;
          th_run_d   = 1'b1;
        end
      end
      PAGE_DATA: begin
        axis_dma_read_data_ready = 1'b1;
        if (axis_dma_read_data_valid) begin
          if (rec_in != beat_cnt_q + transfer_offset) begin
            if (error_cnt_q != '1) error_cnt_d = error_cnt_q + 32'd1;
            if (error_cnt_q == '0) error_index_d = beat_cnt_q;
          end
          // Flags an early last as well as a missing last on the expected final beat.
          if (axis_dma_read_data_last != (beat_cnt_q == last_idx)) len_error_d = 1'b1;
          if (axis_dma_read_data_last) begin
            beat_cnt_d = '0;
            state_d    = ADVANCE;
          end else begin
            beat_cnt_d = beat_cnt_q + 32'd1;
          end
        end
      end
      ADVANCE: begin
        gpu_read_count_d = gpu_read_count_q + 32'd1;
        remain_new       = (remain_q > rec_len_q) ? remain_q - rec_len_q : '0;
        remain_d         = remain_new;
        if (page_idx_q + 32'd1 == work_page_size) begin
          page_idx_d  = '0;
          page_addr_d = start_addr_q;
        end else begin
          page_idx_d  = page_idx_q + 32'd1;
          page_addr_d = page_addr_q + PAGE_STEP;
        end
        if (ctrl_idx_q == CTRL_LAST) begin
          ctrl_idx_d  = '0;
          ctrl_addr_d = transfer_base_addr;
        end else begin
          ctrl_idx_d  = ctrl_idx_q + 32'd1;
          ctrl_addr_d = ctrl_addr_q + 64'd64;
        end
        state_d = (remain_new == '0) ? DONE : WAIT_AVAIL;
      end
      DONE: begin
        state_d  = IDLE;
        th_run_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= IDLE;
      start_r_q        <= 1'b0;
      start_rr_q       <= 1'b0;
      start_addr_q     <= '0;
      page_addr_q      <= '0;
      ctrl_addr_q      <= '0;
      remain_q         <= '0;
      page_idx_q       <= '0;
      ctrl_idx_q       <= '0;
      rec_len_q        <= '0;
      beat_cnt_q       <= '0;
      gpu_read_count_q <= '0;
      error_cnt_q      <= '0;
      error_index_q    <= '0;
      len_error_q      <= 1'b0;
      th_run_q         <= 1'b0;
      rd_th_sum_q      <= '0;
    end else begin
      state_q          <= state_d;
      start_r_q        <= transfer_start;
      start_rr_q       <= start_r_q;
      start_addr_q     <= start_addr_d;
      page_addr_q      <= page_addr_d;
      ctrl_addr_q      <= ctrl_addr_d;
      remain_q         <= remain_d;
      page_idx_q       <= page_idx_d;
      ctrl_idx_q       <= ctrl_idx_d;
      rec_len_q        <= rec_len_d;
      beat_cnt_q       <= beat_cnt_d;
      gpu_read_count_q <= gpu_read_count_d;
      error_cnt_q      <= error_cnt_d;
      error_index_q    <= error_index_d;
      len_error_q      <= len_error_d;
      th_run_q         <= th_run_d;
      rd_th_sum_q      <= rd_th_sum_d;
    end
  end

  assign gpu_read_count = gpu_read_count_q;
  assign error_cnt      = error_cnt_q;
  assign error_index    = error_index_q;
  assign len_error      = len_error_q;
  assign busy           = (state_q != IDLE);
  assign rd_th_sum      = rd_th_sum_q;
endmodule

// File: tb/tb_dma_page_reader.sv
// Directed bench for dma_page_reader: a DMA memory model answers read commands, and a scoreboard checks every accepted command.
module tb_dma_page_reader;
  localparam int PS = 2048;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] len;
  } cmd_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cmd_valid, cmd_ready = 1'b0;
  logic [63:0]  cmd_address;
  logic [31:0]  cmd_length;
  logic [511:0] d_data = '0;
  logic [63:0]  d_keep = '1;
  logic         d_last = 1'b0, d_valid = 1'b0, d_ready;
  logic [63:0]  base_addr = '0;
  logic [31:0]  start_page = '0, tlen = '0, toff = '0, wps = 32'd1;
  logic         tstart = 1'b0;
  logic [31:0]  gwc = '0;
  logic [31:0]  grc, err_cnt, err_idx;
  logic         len_err, busy;
  logic [31:0]  th_sum;

  int checks = 0, errors = 0, cmd_cnt = 0, cyc = 0, page_seq = 0;
  bit abort = 0;
  cmd_t exp_cmd_q[$];
  cmd_t pend_q[$];
  logic [511:0] rec_q[$];
  int corrupt_beat[8];
  int last_at[8];
  logic [63:0] cur_base = '0;
  logic [31:0] cur_off = '0;

  dma_page_reader #(.PAGE_SIZE(PS), .CTRL_NUM(4), .TIMER_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .axis_dma_read_cmd_valid(cmd_valid), .axis_dma_read_cmd_ready(cmd_ready),
    .axis_dma_read_cmd_address(cmd_address), .axis_dma_read_cmd_length(cmd_length),
    .axis_dma_read_data_data(d_data), .axis_dma_read_data_keep(d_keep),
    .axis_dma_read_data_last(d_last), .axis_dma_read_data_valid(d_valid),
    .axis_dma_read_data_ready(d_ready),
    .transfer_base_addr(base_addr), .transfer_start_page(start_page),
    .transfer_length(tlen), .transfer_offset(toff), .work_page_size(wps),
    .transfer_start(tstart), .gpu_write_count(gwc), .gpu_read_count(grc),
    .error_cnt(err_cnt), .error_index(err_idx), .len_error(len_err),
    .busy(busy), .rd_th_sum(th_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rec(input logic [31:0] len, input logic vld);
    logic [511:0] r;
    r = '0;
    r[511] = vld;
    r[31:0] = len;
    return r;
  endfunction

  function automatic int page_opt(input int sel, input int idx);
    if (idx >= 8) return -1;
    return (sel == 0) ? corrupt_beat[idx] : last_at[idx];
  endfunction

  task automatic expect_cmd(input logic [63:0] a, input logic [31:0] l);
    cmd_t c;
    c.addr = a;
    c.len = l;
    exp_cmd_q.push_back(c);
  endtask

  // Command monitor: drives a ready pattern and scores each accepted command.
  initial begin
    cmd_t c, e;
    forever begin
      @(negedge clk);
      cyc++;
      cmd_ready = (cyc % 3) != 1;
      if (rstn && cmd_valid && cmd_ready) begin
        cmd_cnt++;
        c.addr = cmd_address;
        c.len = cmd_length;
        pend_q.push_back(c);
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd got=%0h/%0h exp=none", c.addr, c.len);
        end else begin
          e = exp_cmd_q.pop_front();
          if (c !== e) begin
            errors++;
            $display("FAIL cmd got=%0h/%0h exp=%0h/%0h", c.addr, c.len, e.addr, e.len);
          end
        end
      end
    end
  end

  task automatic drive_beat(input logic [511:0] d, input logic l);
    int n;
    n = 0;
    d_data = d;
    d_last = l;
    d_valid = 1'b1;
    while (!d_ready && rstn && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rstn || n >= 2000) begin
      abort = 1;
      d_valid = 1'b0;
      return;
    end
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic serve(input cmd_t c);
    logic [511:0] d;
    int nb, lastb, cb;
    abort = 0;
    if (c.addr < cur_base + 64'(PS)) begin
      d = (rec_q.size() > 0) ? rec_q.pop_front() : '0;
      drive_beat(d, 1'b1);
    end else begin
      nb = int'(c.len) / 64;
      lastb = (page_opt(1, page_seq) >= 0) ? page_opt(1, page_seq) : nb - 1;
      cb = page_opt(0, page_seq);
      for (int i = 0; i <= lastb; i++) begin
        d = '0;
        d[31:0] = (i == cb) ? 32'h0 : 32'(i) + cur_off;
        drive_beat(d, i == lastb);
        if (abort) break;
      end
      page_seq++;
    end
  endtask

  // DMA memory model: answers commands in order.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (pend_q.size() > 0 && rstn) begin
        c = pend_q.pop_front();
        serve(c);
      end
    end
  end

  task automatic start_run(input logic [63:0] b, input logic [31:0] sp, input logic [31:0] w,
                           input logic [31:0] l, input logic [31:0] o);
    for (int i = 0; i < 8; i++) begin
      corrupt_beat[i] = -1;
      last_at[i] = -1;
    end
    page_seq = 0;
    cur_base = b;
    cur_off = o;
    base_addr = b;
    start_page = sp;
    wps = w;
    tlen = l;
    toff = o;
    tstart = 1'b1;
  endtask

  task automatic wait_busy(input string nm);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_busy_rise"}, busy, 1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    wait_busy(nm);
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, busy, 0);
    tstart = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, "_cmds_left"}, exp_cmd_q.size(), 0);
  endtask

  initial begin
    int c0, n;
    for (int i = 0; i < 8; i++) begin
      corrupt_beat[i] = -1;
      last_at[i] = -1;
    end
    repeat (3) @(negedge clk);
    chk("rst_grc", grc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_data_ready", d_ready, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length run goes straight to DONE without commands.
    start_run(64'h1000_0000, 2, 4, 0, 0);
    wait_done("t0");
    chk("t0_cmds", cmd_cnt, 0);
    chk("t0_th_sum", th_sum, 0);

    // Three full pages, offset 5.
    gwc = 3;
    for (int i = 0; i < 3; i++) begin
      rec_q.push_back(rec(32'h800, 1'b1));
      expect_cmd(64'h1000_0000 + 64'(i) * 64'h40, 32'h40);
      expect_cmd(64'h1000_1000 + 64'(i) * 64'h800, 32'h800);
    end
    start_run(64'h1000_0000, 2, 4, 3 * PS, 5);
    wait_done("t1");
    chk("t1_grc", grc, 3);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_len_err", len_err, 0);
    chk("t1_th_nonzero", th_sum != 0, 1);

    // No credit: the reader must stall until the producer count moves.
    rec_q.push_back(rec(32'h800, 1'b1));
    expect_cmd(64'h1000_0000, 32'h40);
    expect_cmd(64'h1000_1000, 32'h800);
    c0 = cmd_cnt;
    start_run(64'h1000_0000, 2, 4, PS, 0);
    wait_busy("t2");
    repeat (20) @(negedge clk);
    chk("t2_stall_busy", busy, 1);
    chk("t2_stall_cmds", cmd_cnt - c0, 0);
    gwc = 4;
    wait_done("t2");
    chk("t2_cmds", cmd_cnt - c0, 2);
    chk("t2_grc", grc, 4);

    // Page ring wraps every 2 pages, control ring wraps after slot 3.
    gwc = 9;
    for (int i = 0; i < 5; i++) begin
      rec_q.push_back(rec(32'h100, 1'b1));
      expect_cmd(64'h2000_0000 + 64'(i % 4) * 64'h40, 32'h40);
      expect_cmd(((i % 2) == 0) ? 64'h2000_0800 : 64'h2000_1000, 32'h100);
    end
    start_run(64'h2000_0000, 1, 2, 32'h500, 7);
    wait_done("t3");
    chk("t3_grc", grc, 9);
    chk("t3_err_cnt", err_cnt, 0);

    // Corrupted beats: first mismatch index is kept, count keeps growing.
    gwc = 11;
    for (int i = 0; i < 2; i++) begin
      rec_q.push_back(rec(32'h800, 1'b1));
      expect_cmd(64'h1000_0000 + 64'(i) * 64'h40, 32'h40);
      expect_cmd(64'h1000_1000 + 64'(i) * 64'h800, 32'h800);
    end
    start_run(64'h1000_0000, 2, 4, 2 * PS, 32'h10);
    corrupt_beat[0] = 17;
    corrupt_beat[1] = 3;
    wait_done("t4");
    chk("t4_err_cnt", err_cnt, 2);
    chk("t4_err_idx", err_idx, 17);
    chk("t4_len_err", len_err, 0);
    chk("t4_grc", grc, 11);

    // Malformed records: invalid flag, then a length that is not a multiple of 64.
    gwc = 12;
    rec_q.push_back(rec(32'h800, 1'b0));
    expect_cmd(64'h3000_0000, 32'h40);
    start_run(64'h3000_0000, 1, 4, PS, 0);
    wait_done("t5a");
    chk("t5a_len_err", len_err, 1);
    chk("t5a_grc", grc, 11);
    rec_q.push_back(rec(32'h30, 1'b1));
    expect_cmd(64'h3000_0000, 32'h40);
    start_run(64'h3000_0000, 1, 4, PS, 0);
    wait_done("t5b");
    chk("t5b_len_err", len_err, 1);
    chk("t5b_grc", grc, 11);

    // Early last on beat 2 of 4, then a last that arrives two beats late.
    rec_q.push_back(rec(32'h100, 1'b1));
    expect_cmd(64'h3000_0000, 32'h40);
    expect_cmd(64'h3000_0800, 32'h100);
    start_run(64'h3000_0000, 1, 4, 32'h100, 0);
    last_at[0] = 2;
    wait_done("t5c");
    chk("t5c_len_err", len_err, 1);
    chk("t5c_grc", grc, 12);
    chk("t5c_err_cnt", err_cnt, 0);
    gwc = 13;
    rec_q.push_back(rec(32'h100, 1'b1));
    expect_cmd(64'h3000_0000, 32'h40);
    expect_cmd(64'h3000_0800, 32'h100);
    start_run(64'h3000_0000, 1, 4, 32'h100, 0);
    last_at[0] = 5;
    wait_done("t5d");
    chk("t5d_len_err", len_err, 1);
    chk("t5d_grc", grc, 13);
    chk("t5d_err_cnt", err_cnt, 0);

    // Producer count behind the reader by one is a modulo-2^32 difference, so a page is available.
    gwc = 12;
    rec_q.push_back(rec(32'h800, 1'b1));
    expect_cmd(64'h4000_0000, 32'h40);
    expect_cmd(64'h4000_1800, 32'h800);
    start_run(64'h4000_0000, 3, 4, PS, 9);
    wait_done("t6");
    chk("t6_grc", grc, 14);
    chk("t6_len_err", len_err, 0);
    chk("t6_err_cnt", err_cnt, 0);

    // Reset in the middle of page data.
    gwc = 20;
    rec_q.push_back(rec(32'h800, 1'b1));
    expect_cmd(64'h5000_0000, 32'h40);
    expect_cmd(64'h5000_0800, 32'h800);
    c0 = cmd_cnt;
    start_run(64'h5000_0000, 1, 4, PS, 0);
    n = 0;
    while (cmd_cnt - c0 < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t7_cmds_before_rst", cmd_cnt - c0, 2);
    repeat (6) @(negedge clk);
    chk("t7_in_page_data", d_ready, 1);
    rstn = 1'b0;
    tstart = 1'b0;
    repeat (2) @(negedge clk);
    chk("t7_grc", grc, 0);
    chk("t7_err_cnt", err_cnt, 0);
    chk("t7_err_idx", err_idx, 0);
    chk("t7_len_err", len_err, 0);
    chk("t7_busy", busy, 0);
    chk("t7_th_sum", th_sum, 0);
    chk("t7_cmd_valid", cmd_valid, 0);
    chk("t7_data_ready", d_ready, 0);
    exp_cmd_q.delete();
    pend_q.delete();
    rec_q.delete();
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_idle_after_rst", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_page_reader.md
Name: dma_page_reader

Overview:
Consumer-side counterpart of the page-ring DMA writer. Reads back pages and their 64-byte control records from the shared page ring in host/GPU memory, using DMA read commands. Checks each page's incrementing data pattern and advances gpu_read_count, which returns to the writer as its flow-control credit. Sits beside the writer on the same DMA read command and data channels, driven by the same control registers.

Parameters:
PAGE_SIZE, 2*1024*1024, bytes per ring page; power of two.
CTRL_NUM, 1024, number of 64-byte control slots at transfer_base_addr.
TIMER_W, 32, width of the throughput cycle counter.

Ports:
clk  in  1  user clock
rstn  in  1  reset, synchronous, active-low
axis_dma_read_cmd  axis_mem_cmd.master  {address 64, length 32, valid, ready}  DMA read requests
axis_dma_read_data  axi_stream.slave  {data 512, keep 64, last, valid, ready}  DMA read returns
transfer_base_addr  in  64  base of control slots; page ring base is transfer_base_addr + transfer_start_page*PAGE_SIZE
transfer_start_page  in  32  first ring page index
transfer_length  in  32  total payload bytes to consume
transfer_offset  in  32  data pattern offset
work_page_size  in  32  pages in ring, >=1
transfer_start  in  1  level; rising edge starts a run
gpu_write_count  in  32  producer page count, free-running, wraps
gpu_read_count  out  32  pages consumed, free-running, wraps
error_cnt  out  32  mismatching beats this run
error_index  out  32  beat index of first mismatch in its page
len_error  out  1  sticky: record length malformed or last misplaced
busy  out  1  high from START to DONE
rd_th_sum  out  TIMER_W  cycles from first command accept to DONE

Behaviour:
- transfer_start passes through two flops; a start edge is r & ~rr. The edge is ignored unless the FSM is IDLE. On the edge: latch start_addr and remain = transfer_length; set page_idx=0, ctrl_idx=0, page_addr=start_addr, ctrl_addr=transfer_base_addr; clear error_cnt, error_index, len_error and rd_th_sum. gpu_read_count is not cleared.
- States: IDLE, START, WAIT_AVAIL, CTRL_CMD, CTRL_DATA, PAGE_CMD, PAGE_DATA, ADVANCE, DONE.
- START -> WAIT_AVAIL. If remain==0, go to DONE instead.
- WAIT_AVAIL: a page is available when (gpu_write_count - gpu_read_count) mod 2^32 is nonzero. When available, go to CTRL_CMD; otherwise stay.
- CTRL_CMD: drive valid=1, address=ctrl_addr, length=32'h40. On valid&ready, go to CTRL_DATA.
- CTRL_DATA: data.ready=1. On the beat, latch rec_len=data[31:0]. The beat must carry last.
  - If data[511]==0, rec_len==0, rec_len[5:0]!=0, rec_len>PAGE_SIZE, or last==0: set len_error and go to DONE.
  - Otherwise go to PAGE_CMD.
- PAGE_CMD: drive valid=1, address=page_addr, length=rec_len. On handshake, go to PAGE_DATA with beat_cnt=0.
- PAGE_DATA: data.ready=1. Each accepted beat compares data[31:0] with beat_cnt+transfer_offset, 32-bit wrap.
  - On mismatch: error_cnt saturates at all-ones. On the first mismatch of the run, error_index=beat_cnt.
  - last is expected exactly on beat (rec_len>>6)-1. Early or missing last sets len_error. On an early last, leave for ADVANCE anyway. After (rec_len>>6) beats without last, keep accepting beats until last arrives, then leave.
  - beat_cnt resets to 0 on last.
- ADVANCE (one cycle):
  - gpu_read_count += 1.
  - remain -= rec_len, saturating at 0.
  - page_idx+1: if it equals work_page_size, reset to 0 and page_addr=start_addr; otherwise page_addr += PAGE_SIZE.
  - ctrl_idx+1: at CTRL_NUM, reset to 0 and ctrl_addr=transfer_base_addr; otherwise ctrl_addr += 64.
  - Next state is DONE if the new remain==0, else WAIT_AVAIL.
- DONE -> IDLE. rd_th_sum stops counting.
- cmd.valid is high only in CTRL_CMD/PAGE_CMD. address and length are stable while valid is low-to-accepted.
- data.ready is 0 outside CTRL_DATA/PAGE_DATA.
- rd_th_sum counts every cycle after the first command handshake until DONE.
- Reset at any point: FSM goes to IDLE and all outputs and counters go to 0. In-flight DMA returns are not drained; the system must reset the DMA engine too.
- Simultaneous events: a gpu_write_count change in the same cycle as ADVANCE is evaluated in WAIT_AVAIL on the following cycle. A start edge while busy is dropped.

Test Plan:
1. base=0x1000_0000, start_page=2, work_page_size=4, transfer_length=3*PAGE_SIZE, offset=5; gpu_write_count steps to 3. Response:
   - reads at 0x1000_0000/0x40 then 0x1040_0000/0x200000, ctrl +0x40, page +PAGE_SIZE;
   - gpu_read_count=3, error_cnt=0, len_error=0, DONE.
2. gpu_write_count held equal to gpu_read_count -> FSM stays in WAIT_AVAIL, no cmd.valid. Raise gpu_write_count by 1 -> exactly one CTRL_CMD.
3. work_page_size=2 over 5 pages -> page addresses return to start_addr after every 2 pages. CTRL_NUM=4 override -> ctrl_addr wraps to base after slot 3.
4. Corrupt beat 17 of page 0 (data=0) -> error_cnt=1, error_index=17, run still completes.
5. Record with data[511]=0 or rec_len=0x30 -> len_error=1, DONE, no PAGE_CMD. Page data with last on beat 2 of 4 -> len_error=1, counters advance.
6. gpu_read_count=0xFFFF_FFFF, gpu_write_count=0 -> page available, count wraps to 0. Assert rstn low mid-PAGE_DATA -> all outputs 0, IDLE.
